axi_lite_regfile: RTL and testbench

- AXI-Lite slave register bank; the endpoint that sits directly downstream of the 1xM address-decoding bridge on one of its slave ports.
- Holds NUM_REGS word registers within a 2^WINDOW_BITS-byte window.
- Accepts AW and W independently and in either order, then returns B. Serves reads with 1-cycle latency.
- Exposes all register contents to local hardware as a flat bus.

---
 rtl/axi_lite_regfile.sv | 181 ++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI-Lite slave register bank with NUM_REGS word registers
// decoded from the low WINDOW_BITS address bits.
//   clk, rst_n          : clock, asynchronous active-low reset
//   aw_* / w_* / b_*    : write address, write data and write response channels
//   ar_* / r_*          : read address and read data channels
//   regs_o              : all registers, register i at [i*DATA_WIDTH +: DATA_WIDTH]
// Optional build macro AXI_LITE_REGFILE_SLVERR_EN: out-of-range accesses answer
// SLVERR instead of OKAY. Out-of-range writes are always dropped and
// out-of-range reads always return zero data.
module axi_lite_regfile #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WINDOW_BITS = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          aw_addr,
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_strb,
  input  logic                           w_valid,
  output logic                           w_ready,
  output logic [1:0]                     b_resp,
  output logic                           b_valid,
  input  logic                           b_ready,
  input  logic [ADDR_WIDTH-1:0]          ar_addr,
  input  logic                           ar_valid,
  output logic                           ar_ready,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                     r_resp,
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned LSB       = $clog2(STRB_W);
  localparam int unsigned WIN_IDX_W = WINDOW_BITS - LSB;
  localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  // Address decode for both channels
  logic [WIN_IDX_W-1:0] aw_win_idx, ar_win_idx;
  logic [IDX_W-1:0]     aw_idx_c, ar_idx_c;
  logic                 aw_in_range_c, ar_in_range_c;

  assign aw_win_idx    = aw_addr[WINDOW_BITS-1:LSB];
  assign ar_win_idx    = ar_addr[WINDOW_BITS-1:LSB];
  assign aw_in_range_c = {1'b0, aw_win_idx} < (WIN_IDX_W+1)'(NUM_REGS);
  assign ar_in_range_c = {1'b0, ar_win_idx} < (WIN_IDX_W+1)'(NUM_REGS);
  assign aw_idx_c      = IDX_W'(aw_win_idx);
  assign ar_idx_c      = IDX_W'(ar_win_idx);

  // Upper bits were decoded by the bridge; sub-word bits carry no meaning here
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr[ADDR_WIDTH-1:WINDOW_BITS], aw_addr[LSB-1:0],
                              ar_addr[ADDR_WIDTH-1:WINDOW_BITS], ar_addr[LSB-1:0]};

  // State
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  aw_ok_q, aw_ok_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;

  // Readies depend on state only (plus r_ready for the read pass-through)
  assign aw_ready = !aw_held_q && !b_valid_q;
  assign w_ready  = !w_held_q && !b_valid_q;
  assign ar_ready = !r_valid_q || r_ready;

  assign b_valid = b_valid_q;
  assign b_resp  = b_resp_q;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign r_resp  = r_resp_q;
  assign regs_o  = regs_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= {NUM_REGS{RESET_VAL}};
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // Next-state: channel capture, write commit, read response
  always_comb begin
    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;

    if (aw_valid && aw_ready) begin
      aw_held_d = 1'b1;
      aw_idx_d  = aw_idx_c;
      aw_ok_d   = aw_in_range_c;
    end
    if (w_valid && w_ready) begin
      w_held_d = 1'b1;
      w_data_d = w_data;
      w_strb_d = w_strb;
    end

    if (b_valid_q && b_ready) begin
      b_valid_d = 1'b0;
    end

    // Both halves held: commit strobed bytes and raise the response
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = aw_ok_q ? RESP_OKAY : RESP_OOR;
      if (aw_ok_q) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (w_strb_q[b]) begin
            regs_d[aw_idx_q][b*8 +: 8] = w_data_q[b*8 +: 8];
          end
        end
      end
    end

    if (r_valid_q && r_ready) begin
      r_valid_d = 1'b0;
    end
    // Reads sample regs_q, so a same-edge commit is not yet visible
    if (ar_valid && ar_ready) begin
      r_valid_d = 1'b1;
      r_data_d  = ar_in_range_c ? regs_q[ar_idx_c] : '0;
      r_resp_d  = ar_in_range_c ? RESP_OKAY : RESP_OOR;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: randomized and directed bench for axi_lite_regfile with a
// transaction-level model (register array plus AW/W queues) compared every cycle.
module tb_axi_lite_regfile;

  localparam logic [31:0] RST_VAL = 32'hDEAD_0000;
`ifdef AXI_LITE_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic         clk, rst_n;
  logic [31:0]  aw_addr, w_data, ar_addr, r_data;
  logic         aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic         ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]   w_strb;
  logic [1:0]   b_resp, r_resp;
  logic [511:0] regs_o;

  axi_lite_regfile #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WINDOW_BITS(12),
    .RESET_VAL(RST_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .regs_o(regs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within cycle budget at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [16];
  int          m_aw_q [$];          // accepted write indices not yet committed
  logic [35:0] m_w_q  [$];          // accepted {strb, data} not yet committed
  bit          m_b_v, m_r_v;
  logic [1:0]  m_b_resp, m_r_resp;
  logic [31:0] m_r_data;

  function automatic bit exp_aw_rdy();
    return (m_aw_q.size() == 0) && !m_b_v;
  endfunction
  function automatic bit exp_w_rdy();
    return (m_w_q.size() == 0) && !m_b_v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = RST_VAL;
    m_aw_q.delete();
    m_w_q.delete();
    m_b_v = 0; m_r_v = 0;
    m_b_resp = 2'b00; m_r_resp = 2'b00; m_r_data = '0;
  endtask

  task automatic model_compare();
    logic [511:0] flat;
    for (int i = 0; i < 16; i++) flat[i*32 +: 32] = m_regs[i];
    chk("regs_o", regs_o, flat);
    chk("aw_ready", aw_ready, exp_aw_rdy());
    chk("w_ready", w_ready, exp_w_rdy());
    chk("ar_ready", ar_ready, !m_r_v || r_ready);
    chk("b_valid", b_valid, m_b_v);
    chk("r_valid", r_valid, m_r_v);
    if (m_b_v) chk("b_resp", b_resp, m_b_resp);
    if (m_r_v) begin
      chk("r_data", r_data, m_r_data);
      chk("r_resp", r_resp, m_r_resp);
    end
  endtask

  // Advance the model across the coming clock edge using the inputs now applied
  task automatic model_step();
    bit aw_hs, w_hs, ar_hs;
    int idx;
    logic [35:0] wd;
    aw_hs = aw_valid && exp_aw_rdy();
    w_hs  = w_valid && exp_w_rdy();
    ar_hs = ar_valid && (!m_r_v || r_ready);
    if (ar_hs) begin
      idx = int'(ar_addr[11:2]);
      m_r_v = 1;
      m_r_data = (idx < 16) ? m_regs[idx] : 32'h0;
      m_r_resp = (idx < 16) ? 2'b00 : OOR_RESP;
    end else if (m_r_v && r_ready) begin
      m_r_v = 0;
    end
    if (m_b_v && b_ready) m_b_v = 0;
    if (m_aw_q.size() > 0 && m_w_q.size() > 0) begin
      idx = m_aw_q.pop_front();
      wd  = m_w_q.pop_front();
      if (idx < 16)
        for (int b = 0; b < 4; b++)
          if (wd[32+b]) m_regs[idx][b*8 +: 8] = wd[b*8 +: 8];
      m_b_v = 1;
      m_b_resp = (idx < 16) ? 2'b00 : OOR_RESP;
    end
    if (aw_hs) m_aw_q.push_back(int'(aw_addr[11:2]));
    if (w_hs) m_w_q.push_back({w_strb, w_data});
  endtask

  // Single compare process, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        chk("rst_r_data", r_data, 32'h0);
        chk("rst_b_resp", b_resp, 2'b00);
        chk("rst_r_resp", r_resp, 2'b00);
      end
      model_compare();
      if (rst_n) model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead);
    int aw_start, w_start;
    bit aw_done, w_done, hs_aw, hs_w;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0;
    for (int cyc = 0; cyc < 300 && !(aw_done && w_done); cyc++) begin
      if (!aw_done && cyc >= aw_start) begin aw_addr = addr; aw_valid = 1; end
      if (!w_done && cyc >= w_start) begin w_data = data; w_strb = strb; w_valid = 1; end
      @(negedge clk);
      hs_aw = aw_valid && aw_ready;
      hs_w  = w_valid && w_ready;
      next_cycle();
      if (hs_aw) begin aw_done = 1; aw_valid = 0; end
      if (hs_w) begin w_done = 1; w_valid = 0; end
    end
    if (!(aw_done && w_done)) begin
      aw_valid = 0; w_valid = 0;
      timeout("write_handshake");
    end
  endtask

  task automatic axi_read(input logic [31:0] addr);
    bit hs;
    hs = 0;
    ar_addr = addr; ar_valid = 1;
    for (int cyc = 0; cyc < 300 && !hs; cyc++) begin
      @(negedge clk);
      hs = ar_ready;
      next_cycle();
    end
    ar_valid = 0;
    if (!hs) timeout("read_handshake");
  endtask

  // Read with r_ready high; data must be present in the cycle after the AR handshake
  task automatic read_expect(input string name, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
    axi_read(addr);
    @(negedge clk);
    chk({name, "_valid"}, r_valid, 1'b1);
    chk({name, "_data"}, r_data, exp_data);
    chk({name, "_resp"}, r_resp, exp_resp);
    next_cycle();
  endtask

  bit wr_done, rd_done;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0;
    aw_addr = '0; aw_valid = 0; w_data = '0; w_strb = '0; w_valid = 0;
    ar_addr = '0; ar_valid = 0; b_ready = 1; r_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    next_cycle();

    // Reset values visible through reads
    for (int i = 0; i < 16; i++) read_expect("rst_read", 32'(i * 4), 32'hDEAD_0000, 2'b00);

    // AW and W on the same edge
    axi_write(32'h0000_1008, 32'h1234_5678, 4'hF, 0);
    @(negedge clk);
    @(negedge clk);
    chk("same_b_valid", b_valid, 1'b1);
    chk("same_b_resp", b_resp, 2'b00);
    chk("same_reg2", regs_o[2*32 +: 32], 32'h1234_5678);
    next_cycle();
    read_expect("same_read", 32'h0000_1008, 32'h1234_5678, 2'b00);

    // W three cycles ahead of AW, partial strobes
    axi_write(32'h0000_0004, 32'h1111_1111, 4'hF, 0);
    axi_write(32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 3);
    repeat (2) next_cycle();
    chk("wfirst_reg1", regs_o[1*32 +: 32], 32'h11BB_11DD);

    // B backpressure; a second write waits for the B handshake
    b_ready = 0;
    axi_write(32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0);
    fork
      axi_write(32'h0000_0014, 32'h0BAD_BEEF, 4'hF, 0);
      begin
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("bp_b_valid", b_valid, 1'b1);
          chk("bp_b_resp", b_resp, 2'b00);
          chk("bp_aw_ready", aw_ready, 1'b0);
          chk("bp_w_ready", w_ready, 1'b0);
        end
        next_cycle();
        b_ready = 1;
      end
    join
    @(negedge clk);
    @(negedge clk);
    chk("bp_reg5", regs_o[5*32 +: 32], 32'h0BAD_BEEF);
    chk("bp_reg4", regs_o[4*32 +: 32], 32'hCAFE_F00D);
    next_cycle();

    // Read colliding with a commit to the same index returns the old value
    axi_write(32'h0000_000C, 32'h1357_9BDF, 4'hF, 0);
    repeat (3) next_cycle();
    axi_write(32'h0000_000C, 32'h3333_3333, 4'hF, 0);
    read_expect("collide", 32'h0000_000C, 32'h1357_9BDF, 2'b00);
    read_expect("after_collide", 32'h0000_000C, 32'h3333_3333, 2'b00);

    // R backpressure with back-to-back ARs to index 3 then 4
    r_ready = 0;
    ar_addr = 32'h0000_000C; ar_valid = 1;
    next_cycle();
    ar_addr = 32'h0000_0010;
    repeat (4) begin
      @(negedge clk);
      chk("rbp_valid", r_valid, 1'b1);
      chk("rbp_data", r_data, 32'h3333_3333);
      chk("rbp_ar_ready", ar_ready, 1'b0);
      next_cycle();
    end
    r_ready = 1;
    next_cycle();
    ar_valid = 0;
    @(negedge clk);
    chk("rbp_next_valid", r_valid, 1'b1);
    chk("rbp_next_data", r_data, 32'hCAFE_F00D);
    next_cycle();

    // Out-of-range index 20
    axi_write(32'h0000_0050, 32'hFFFF_FFFF, 4'hF, 0);
    @(negedge clk);
    @(negedge clk);
    chk("oor_b_valid", b_valid, 1'b1);
    chk("oor_b_resp", b_resp, OOR_RESP);
    next_cycle();
    read_expect("oor_read", 32'h0000_0050, 32'h0, OOR_RESP);

    // Reset while an AW is held: the held AW must not pair with a later W
    aw_addr = 32'h0000_0018; aw_valid = 1;
    next_cycle();
    aw_valid = 0;
    rst_n = 0;
    repeat (2) next_cycle();
    rst_n = 1;
    w_data = 32'h5A5A_A5A5; w_strb = 4'hF; w_valid = 1;
    next_cycle();
    w_valid = 0;
    repeat (4) begin
      @(negedge clk);
      chk("no_b_after_rst", b_valid, 1'b0);
      next_cycle();
    end
    aw_addr = 32'h0000_0018; aw_valid = 1;
    next_cycle();
    aw_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_b", b_valid, 1'b1);
    chk("post_rst_reg6", regs_o[6*32 +: 32], 32'h5A5A_A5A5);
    chk("post_rst_reg2", regs_o[2*32 +: 32], 32'hDEAD_0000);
    next_cycle();

    // Randomized traffic on both channels with random backpressure
    wr_done = 0; rd_done = 0;
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          int idx, lead;
          logic [31:0] addr;
          idx  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 19));
          lead = int'($urandom_range(0, 6)) - 3;
          addr = $urandom();
          addr[11:2] = 10'(idx);
          axi_write(addr, $urandom(), 4'($urandom_range(0, 15)), lead);
          repeat ($urandom_range(0, 2)) next_cycle();
        end
        wr_done = 1;
      end
      begin
        for (int n = 0; n < 150; n++) begin
          logic [31:0] addr;
          addr = $urandom();
          addr[11:2] = 10'($urandom_range(0, 19));
          axi_read(addr);
          repeat ($urandom_range(0, 2)) next_cycle();
        end
        rd_done = 1;
      end
      begin
        while (!(wr_done && rd_done)) begin
          next_cycle();
          b_ready = 1'($urandom_range(0, 1));
          r_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    b_ready = 1; r_ready = 1;
    repeat (6) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
